// File: rtl/fifo_axis_reader.sv
// Drains a 1-cycle-latency FIFO read port into an AXI4-Stream master, tagging TLAST every PKT_LEN words.
// Latency fifo_empty low -> tvalid 2 clk; 2-entry buffer credit stops FIFO reads while tready is held low.
module fifo_axis_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [CNT_WIDTH-1:0]  pkt_cnt
);

    localparam bit                   FRAMING  = (PKT_LEN > 0);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = FRAMING ? CNT_WIDTH'(PKT_LEN - 1) : '0;

    logic [1:0]            count_q, count_d;
    logic                  inflight_q;
    logic                  tvalid_q;
    logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic                  last0_q, last0_d, last1_q, last1_d;
    logic [CNT_WIDTH-1:0]  push_idx_q, push_idx_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic                  pop;
    logic                  push;
    logic                  push_last;
    logic [2:0]            occupancy;

    assign pop       = tvalid_q & m_axis_tready;
    assign push      = inflight_q;
    assign push_last = FRAMING && (push_idx_q == LAST_IDX);

    // Words held plus the one in flight, after this cycle's pop; must stay below 2 to issue a read.
    assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = ~fifo_empty & (occupancy < 3'd2);

    always_comb begin
        count_d    = count_q;
        data0_d    = data0_q;
        data1_d    = data1_q;
        last0_d    = last0_q;
        last1_d    = last1_q;
        push_idx_d = push_idx_q;
        pkt_cnt_d  = pkt_cnt_q;

        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    data0_d = fifo_rd_data;
                    last0_d = push_last;
                end else begin
                    data1_d = fifo_rd_data;
                    last1_d = push_last;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                data0_d = data1_q;
                last0_d = last1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Pop and push together: head advances, new word lands behind whatever remains.
                if (count_q == 2'd1) begin
                    data0_d = fifo_rd_data;
                    last0_d = push_last;
                end else begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = fifo_rd_data;
                    last1_d = push_last;
                end
            end
            default: ;
        endcase

        if (push && FRAMING) begin
            push_idx_d = push_last ? '0 : push_idx_q + CNT_WIDTH'(1);
        end
        if (pop && FRAMING) begin
            pkt_cnt_d = last0_q ? '0 : pkt_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            tvalid_q   <= 1'b0;
            data0_q    <= '0;
            data1_q    <= '0;
            last0_q    <= 1'b0;
            last1_q    <= 1'b0;
            push_idx_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            count_q    <= count_d;
            inflight_q <= fifo_rd_en;
            tvalid_q   <= (count_d != 2'd0);
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            last0_q    <= last0_d;
            last1_q    <= last1_d;
            push_idx_q <= push_idx_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = data0_q;
    assign m_axis_tlast  = last0_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed bench: PKT_LEN=4 reader fed by a behavioural FIFO, with a PKT_LEN=1 twin on the same FIFO signals.
module tb_fifo_axis_reader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tlast;
    logic [15:0] pkt_cnt;
    logic        rd_en1, tvalid1, tlast1;
    logic [7:0]  tdata1;
    logic [3:0]  pkt_cnt1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fifo_axis_reader #(.DATA_WIDTH(8), .PKT_LEN(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .pkt_cnt(pkt_cnt)
    );

    fifo_axis_reader #(.DATA_WIDTH(8), .PKT_LEN(1), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en1),
        .fifo_rd_data(fifo_rd_data), .m_axis_tvalid(tvalid1), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(tdata1), .m_axis_tlast(tlast1), .pkt_cnt(pkt_cnt1)
    );

    // Behavioural FIFO: rd_data appears the cycle after an accepted read.
    logic [7:0] fq[$];
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fq.delete();
            fifo_empty   <= 1'b1;
            fifo_rd_data <= 8'h00;
        end else begin
            if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
            if (wr_en) fq.push_back(wr_data);
            fifo_empty <= (fq.size() == 0);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0]  got[$];
    logic [15:0] got_pc[$];
    int          got_cyc[$];
    int          rd_cyc[$];
    int          empty_fall = 0;
    int          stab_err = 0;
    int          twin_err = 0;
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_empty = 1'b1;
    logic [7:0]  prev_d = 8'h00;

    always @(negedge clk) begin
        if (!resetn) begin
            prev_v     <= 1'b0;
            prev_empty <= 1'b1;
        end else begin
            if (prev_empty && !fifo_empty) empty_fall <= cyc;
            prev_empty <= fifo_empty;
            if (fifo_rd_en) rd_cyc.push_back(cyc);
            if (m_axis_tvalid && m_axis_tready) begin
                got.push_back({m_axis_tlast, m_axis_tdata});
                got_pc.push_back(pkt_cnt);
                got_cyc.push_back(cyc);
            end
            if (prev_v && !prev_r &&
                (!m_axis_tvalid || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l))
                stab_err <= stab_err + 1;
            prev_v <= m_axis_tvalid;
            prev_r <= m_axis_tready;
            prev_d <= m_axis_tdata;
            prev_l <= m_axis_tlast;
            if (rd_en1 !== fifo_rd_en || tvalid1 !== m_axis_tvalid || pkt_cnt1 !== 4'd0 ||
                (tvalid1 && (tlast1 !== 1'b1 || tdata1 !== m_axis_tdata)))
                twin_err <= twin_err + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_pops(input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (got.size() >= target) break;
            tick(1);
        end
    endtask

    function automatic logic [7:0] pat(input int j);
        return 8'((j * 37 + 5) & 255);
    endfunction

    task automatic test_reset;
        resetn = 1'b0;
        tick(3);
        tests_run++; if (m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
        tests_run++; if (m_axis_tdata !== 8'h00) begin tests_failed++; $display("FAIL reset_tdata: got %h expected 00", m_axis_tdata); end
        tests_run++; if (m_axis_tlast !== 1'b0) begin tests_failed++; $display("FAIL reset_tlast: got %b expected 0", m_axis_tlast); end
        tests_run++; if (pkt_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt); end
        tests_run++; if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
        resetn = 1'b1;
        tick(2);
    endtask

    task automatic test_first_words;
        int mark;
        m_axis_tready = 1'b1;
        mark = got.size();
        for (int i = 0; i < 4; i++) put(8'h11 + 8'(i));
        wait_pops(mark + 4, 30);
        tests_run++;
        if (got.size() < mark + 4) begin
            tests_failed++; $display("FAIL first_timeout: got %0d words expected 4", got.size() - mark);
            return;
        end
        tests_run++; if (got_cyc[mark] - empty_fall !== 2) begin tests_failed++; $display("FAIL first_latency: got %0d expected 2", got_cyc[mark] - empty_fall); end
        tests_run++; if (got_cyc[mark+3] - got_cyc[mark] !== 3) begin tests_failed++; $display("FAIL first_consecutive: got span %0d expected 3", got_cyc[mark+3] - got_cyc[mark]); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (got[mark+i] !== {(i == 3), 8'h11 + 8'(i)}) begin
                tests_failed++; $display("FAIL first_word%0d: got %h expected %h", i, got[mark+i], {(i == 3), 8'h11 + 8'(i)});
            end
        end
    endtask

    task automatic test_back_to_back;
        int mark, r0, bad;
        mark = got.size();
        r0 = rd_cyc.size();
        bad = 0;
        for (int i = 0; i < 16; i++) put(8'h20 + 8'(i));
        wait_pops(mark + 16, 40);
        tick(3);
        tests_run++;
        if (got.size() !== mark + 16) begin
            tests_failed++; $display("FAIL b2b_count: got %0d words expected 16", got.size() - mark);
            return;
        end
        tests_run++; if (rd_cyc.size() - r0 !== 16) begin tests_failed++; $display("FAIL b2b_reads: got %0d expected 16", rd_cyc.size() - r0); end
        tests_run++; if (rd_cyc[rd_cyc.size()-1] - rd_cyc[r0] !== 15) begin tests_failed++; $display("FAIL b2b_rd_run: got span %0d expected 15", rd_cyc[rd_cyc.size()-1] - rd_cyc[r0]); end
        tests_run++; if (got_cyc[mark+15] - got_cyc[mark] !== 15) begin tests_failed++; $display("FAIL b2b_pop_run: got span %0d expected 15", got_cyc[mark+15] - got_cyc[mark]); end
        for (int i = 0; i < 16; i++)
            if (got[mark+i] !== {(i % 4 == 3), 8'h20 + 8'(i)}) bad++;
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL b2b_data: got %0d bad words expected 0", bad); end
        tests_run++; if (pkt_cnt !== 16'd0) begin tests_failed++; $display("FAIL b2b_pkt_cnt: got %0d expected 0", pkt_cnt); end
        tests_run++; if (twin_err !== 0) begin tests_failed++; $display("FAIL pktlen1_twin: got %0d errors expected 0", twin_err); end
    endtask

    task automatic test_backpressure;
        int mark, r0, held_bad;
        m_axis_tready = 1'b0;
        mark = got.size();
        r0 = rd_cyc.size();
        held_bad = 0;
        for (int i = 0; i < 8; i++) put(8'h30 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h30) held_bad++;
        end
        tests_run++; if (rd_cyc.size() - r0 !== 2) begin tests_failed++; $display("FAIL bp_reads: got %0d expected 2", rd_cyc.size() - r0); end
        tests_run++; if (held_bad !== 0) begin tests_failed++; $display("FAIL bp_hold: got %0d bad cycles expected 0", held_bad); end
        m_axis_tready = 1'b1;
        wait_pops(mark + 8, 40);
        tick(3);
        tests_run++;
        if (got.size() !== mark + 8) begin
            tests_failed++; $display("FAIL bp_count: got %0d words expected 8", got.size() - mark);
            return;
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (got[mark+i] !== {(i % 4 == 3), 8'h30 + 8'(i)}) begin
                tests_failed++; $display("FAIL bp_word%0d: got %h expected %h", i, got[mark+i], {(i % 4 == 3), 8'h30 + 8'(i)});
            end
        end
    endtask

    task automatic test_framing;
        int mark;
        mark = got.size();
        for (int i = 0; i < 5; i++) put(8'(i));
        tick(8);
        tests_run++; if (m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL frame_gap_tvalid: got %b expected 0", m_axis_tvalid); end
        tests_run++; if (pkt_cnt !== 16'd1) begin tests_failed++; $display("FAIL frame_gap_pkt_cnt: got %0d expected 1", pkt_cnt); end
        for (int i = 5; i < 10; i++) put(8'(i));
        wait_pops(mark + 10, 40);
        tick(3);
        tests_run++;
        if (got.size() !== mark + 10) begin
            tests_failed++; $display("FAIL frame_count: got %0d words expected 10", got.size() - mark);
            return;
        end
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (got[mark+i] !== {(i == 3 || i == 7), 8'(i)} || got_pc[mark+i] !== 16'(i % 4)) begin
                tests_failed++; $display("FAIL frame_word%0d: got %h cnt %0d expected %h cnt %0d",
                                         i, got[mark+i], got_pc[mark+i], {(i == 3 || i == 7), 8'(i)}, i % 4);
            end
        end
        tests_run++; if (pkt_cnt !== 16'd2) begin tests_failed++; $display("FAIL frame_pkt_cnt: got %0d expected 2", pkt_cnt); end
    endtask

    task automatic test_random;
        int mark, nw, bad, s0;
        mark = got.size();
        s0 = stab_err;
        nw = 0;
        bad = 0;
        while (nw < 1000) begin
            m_axis_tready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) begin
                wr_en = 1'b1; wr_data = pat(nw); nw++;
            end else begin
                wr_en = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        m_axis_tready = 1'b1;
        wait_pops(mark + 1000, 3000);
        tick(3);
        tests_run++;
        if (got.size() !== mark + 1000) begin
            tests_failed++; $display("FAIL rand_count: got %0d words expected 1000", got.size() - mark);
            return;
        end
        // Framing index carries over from earlier tests: 38 words already sent.
        for (int j = 0; j < 1000; j++)
            if (got[mark+j] !== {((j + 2) % 4 == 3), pat(j)}) bad++;
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL rand_order: got %0d bad words expected 0", bad); end
        tests_run++; if (stab_err - s0 !== 0) begin tests_failed++; $display("FAIL rand_axis_stable: got %0d violations expected 0", stab_err - s0); end
        tests_run++; if (twin_err !== 0) begin tests_failed++; $display("FAIL rand_pktlen1_twin: got %0d errors expected 0", twin_err); end
    endtask

    task automatic test_reset_inflight;
        int mark;
        m_axis_tready = 1'b0;
        tick(1);
        put(8'h40);
        tick(4);
        tests_run++; if (pkt_cnt !== 16'd2) begin tests_failed++; $display("FAIL rst_pre_pkt_cnt: got %0d expected 2", pkt_cnt); end
        put(8'h41);
        tests_run++; if (fifo_rd_en !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_rd_en: got %b expected 1", fifo_rd_en); end
        tick(1);
        tests_run++; if (m_axis_tvalid !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_tvalid: got %b expected 1", m_axis_tvalid); end
        #2 resetn = 1'b0;
        #1;
        tests_run++; if (m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_async_tvalid: got %b expected 0", m_axis_tvalid); end
        tests_run++; if (pkt_cnt !== 16'd0) begin tests_failed++; $display("FAIL rst_async_pkt_cnt: got %0d expected 0", pkt_cnt); end
        tick(2);
        resetn = 1'b1;
        tick(1);
        m_axis_tready = 1'b1;
        mark = got.size();
        put(8'h55);
        wait_pops(mark + 1, 20);
        tick(4);
        tests_run++;
        if (got.size() !== mark + 1 || got[mark] !== {1'b0, 8'h55}) begin
            tests_failed++; $display("FAIL rst_next_word: got %0d words first %h expected 1 word 055",
                                     got.size() - mark, (got.size() > mark) ? got[mark] : 9'h000);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    initial begin
        test_reset;
        test_first_words;
        test_back_to_back;
        test_backpressure;
        test_framing;
        test_random;
        test_reset_inflight;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
